// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative AES MixColumns stage, one 32-bit column per clock
// Define MIX_COLUMNS_INV_EN to add the inv port and InvMixColumns support.
module mix_columns_iter #(
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   output logic              in_ready,
   input  logic              last_round,
`ifdef MIX_COLUMNS_INV_EN
   input  logic              inv,
`endif
   input  logic [DATA_W-1:0] data_in,
   output logic              valid_out,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [1:0]        col_cnt;
   logic [DATA_W-1:0] blk;
   logic [31:0]       col_sel;
   logic [31:0]       col_res;
`ifdef MIX_COLUMNS_INV_EN
   logic              inv_reg;
`endif

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] fwd_mix(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

`ifdef MIX_COLUMNS_INV_EN
   // Multiples 9, b, d, e built from a shared x2/x4/x8 chain per byte.
   function automatic logic [31:0] inv_mix(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         x2    = xt(a[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction
`endif

   assign in_ready = (state == IDLE);

   always_comb begin
      col_sel = blk[127:96];
      case (col_cnt)
         2'd0:    col_sel = blk[127:96];
         2'd1:    col_sel = blk[95:64];
         2'd2:    col_sel = blk[63:32];
         default: col_sel = blk[31:0];
      endcase
   end

`ifdef MIX_COLUMNS_INV_EN
   assign col_res = inv_reg ? inv_mix(col_sel) : fwd_mix(col_sel);
`else
   assign col_res = fwd_mix(col_sel);
`endif

   // Bypass enters DONE with valid_out low; it rises on the following clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         col_cnt   <= 2'd0;
         valid_out <= 1'b0;
         data_out  <= '0;
         blk       <= '0;
`ifdef MIX_COLUMNS_INV_EN
         inv_reg   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (valid_in) begin
                  blk     <= data_in;
                  col_cnt <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
                  inv_reg <= inv;
`endif
                  if (last_round) begin
                     data_out <= data_in;
                     state    <= DONE;
                  end else begin
                     state    <= CALC;
                  end
               end
            end
            CALC: begin
               case (col_cnt)
                  2'd0:    data_out[127:96] <= col_res;
                  2'd1:    data_out[95:64]  <= col_res;
                  2'd2:    data_out[63:32]  <= col_res;
                  default: data_out[31:0]   <= col_res;
               endcase
               col_cnt <= col_cnt + 2'd1;
               if (col_cnt == 2'd3) begin
                  state     <= DONE;
                  valid_out <= 1'b1;
               end
            end
            DONE: begin
               if (valid_out && out_ready) begin
                  state     <= IDLE;
                  valid_out <= 1'b0;
               end else begin
                  valid_out <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               valid_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - directed and random checks of mix_columns_iter against a GF(2^8) matrix model
// Define MIX_COLUMNS_INV_EN to also exercise the inverse transform.
module tb_mix_columns_iter;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         valid_in = 1'b0;
   logic         last_round = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] data_in = '0;
   logic         in_ready;
   logic         valid_out;
   logic [127:0] data_out;
`ifdef MIX_COLUMNS_INV_EN
   logic         inv = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   mix_columns_iter #(.DATA_W(128)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .in_ready   (in_ready),
      .last_round (last_round),
`ifdef MIX_COLUMNS_INV_EN
      .inv        (inv),
`endif
      .data_in    (data_in),
      .valid_out  (valid_out),
      .out_ready  (out_ready),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Polynomial multiply then reduce modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] d, input bit last, input bit iv);
      logic [7:0]   m [4];
      logic [7:0]   acc;
      logic [127:0] r;
      if (last) return d;
      if (iv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else    m = '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(m[(j - row + 4) % 4], d[127 - 8*(4*c + j) -: 8]);
            r[127 - 8*(4*c + row) -: 8] = acc;
         end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic send(input logic [127:0] d, input bit last, input bit iv);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("send_in_ready", {127'd0, in_ready}, 128'd1);
      data_in    = d;
      last_round = last;
`ifdef MIX_COLUMNS_INV_EN
      inv        = iv;
`endif
      valid_in   = 1'b1;
      tick();
      valid_in   = 1'b0;
      data_in    = rand128();
      last_round = $urandom_range(0, 1);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!valid_out && lat < 20) begin
         tick();
         lat++;
      end
      chk("wait_valid_out", {127'd0, valid_out}, 128'd1);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("release_in_ready", {127'd0, in_ready}, 128'd1);
      chk("release_valid_out", {127'd0, valid_out}, 128'd0);
   endtask

   initial begin
      logic [127:0] d;
      logic [127:0] exp;
      bit           last;
      bit           iv;
      int           lat;
      int           hold;

      #1;
      chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
      chk("reset_valid_out", {127'd0, valid_out}, 128'd0);
      chk("reset_data_out", data_out, 128'd0);
      tick();
      reset = 1'b1;
      tick();

      // FIPS vector with exact latency
      d = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      send(d, 1'b0, 1'b0);
      repeat (3) tick();
      chk("fips_lat3_low", {127'd0, valid_out}, 128'd0);
      tick();
      chk("fips_lat4_high", {127'd0, valid_out}, 128'd1);
      chk("fips_vector", data_out, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      chk("fips_model", data_out, ref_mix(d, 1'b0, 1'b0));
      chk("fips_in_ready_low", {127'd0, in_ready}, 128'd0);
      release_out();

      // FIPS-197 round 1 columns
      d = {32'hd4bf5d30, 32'hd4d4d4d5, $urandom(), $urandom()};
      send(d, 1'b0, 1'b0);
      wait_out(lat);
      chk("round1_col0", {96'd0, data_out[127:96]}, {96'd0, 32'h046681e5});
      chk("round1_col1", {96'd0, data_out[95:64]}, {96'd0, 32'hd5d5d7d6});
      chk("round1_model", data_out, ref_mix(d, 1'b0, 1'b0));
      release_out();

      // Bypass, then backpressure with ignored valid_in pulses
      d = 128'h00112233_44556677_8899aabb_ccddeeff;
      send(d, 1'b1, 1'b0);
      chk("bypass_lat0_low", {127'd0, valid_out}, 128'd0);
      tick();
      chk("bypass_lat1_high", {127'd0, valid_out}, 128'd1);
      chk("bypass_data", data_out, d);
      for (int i = 0; i < 10; i++) begin
         valid_in = i[0];
         data_in  = rand128();
         tick();
         chk("bp_valid_out", {127'd0, valid_out}, 128'd1);
         chk("bp_data_out", data_out, d);
         chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      end
      valid_in = 1'b0;
      release_out();
      chk("bp_no_capture", data_out, d);

      // Reset in the middle of CALC aborts the block
      send(rand128(), 1'b0, 1'b0);
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("midreset_valid_out", {127'd0, valid_out}, 128'd0);
      chk("midreset_data_out", data_out, 128'd0);
      chk("midreset_in_ready", {127'd0, in_ready}, 128'd1);
      tick();
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("midreset_no_output", {127'd0, valid_out}, 128'd0);
      end
      out_ready = 1'b0;

`ifdef MIX_COLUMNS_INV_EN
      d = {32'h8e4da1bc, $urandom(), $urandom(), $urandom()};
      send(d, 1'b0, 1'b1);
      wait_out(lat);
      chk("inv_col0", {96'd0, data_out[127:96]}, {96'd0, 32'hdb135345});
      chk("inv_model", data_out, ref_mix(d, 1'b0, 1'b1));
      release_out();
`endif

      // Random blocks, random bypass/inverse, random backpressure
      for (int k = 0; k < 40; k++) begin
         d    = rand128();
         last = ($urandom_range(0, 3) == 0);
         iv   = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
         iv   = $urandom_range(0, 1);
`endif
         exp  = ref_mix(d, last, iv);
         send(d, last, iv);
         wait_out(lat);
         chk("rand_latency", 128'(lat), last ? 128'd1 : 128'd4);
         chk("rand_data", data_out, exp);
         hold = $urandom_range(0, 3);
         repeat (hold) tick();
         chk("rand_hold_data", data_out, exp);
         release_out();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
